// File: rtl/id_control_pipe_pkg.sv
// Shared RV32I control definitions: opcode map, ALU op encodings and the
// control bundle carried from ID to EX.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  // MSB first: branch ... illegal
  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       a_sel_pc;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_control_pipe_if.sv
// Handshake bundle between IF/ID (upstream), the ID stage and EX (downstream).
// The slave modport is the ID stage view; master is the environment view.
interface id_control_pipe_if
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [XLEN-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  ctrl_t               out_ctrl;
  logic [REG_AW-1:0]   out_rd;
  logic [REG_AW-1:0]   out_rs1;
  logic [REG_AW-1:0]   out_rs2;
  logic [XLEN-1:0]     out_pc;
  logic [STALL_CW-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_pc, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_pc, stall_cnt
  );
endinterface

// File: rtl/id_control_pipe_ctrl_decode.sv
// Combinational RV32I main decoder: opcode -> control bundle, plus which
// source registers the opcode actually reads (used for hazard matching).
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2
);

  // Decode table; unknown opcodes still flow as illegal so EX can trap.
  always_comb begin
    o_ctrl     = '0;
    o_uses_rs1 = 1'b1;
    o_uses_rs2 = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ARITH;
        o_uses_rs2       = 1'b1;
      end
      OP_IMM: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ARITH;
      end
      OP_LOAD: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALUOP_BR;
        o_uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.a_sel_pc  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_PASS;
        o_uses_rs1       = 1'b0;
      end
      OP_JALR: begin
        o_ctrl.jump      = 1'b1;
        o_ctrl.jalr      = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_PASS;
      end
      OP_LUI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_PASS;
        o_uses_rs1       = 1'b0;
      end
      OP_AUIPC: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.a_sel_pc  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_uses_rs1       = 1'b0;
      end
      default: begin
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_control_pipe.sv
// ID-stage control unit owning the ID/EX control register: decodes the
// instruction, inserts load-use bubbles, honours EX flushes and keeps a
// saturating count of the bubbles it inserted.
module id_control_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int HAZARD_EN = 1,
  parameter int STALL_CW  = 16
) (
  input logic               clk,
  input logic               rst,
  id_control_pipe_if.slave  bus
);

  ctrl_t               w_dec_ctrl;
  logic                w_uses_rs1;
  logic                w_uses_rs2;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs1;
  logic [REG_AW-1:0]   w_rs2;
  logic                w_load_en;
  logic                w_hazard;
  logic                w_unused;

  logic                r_valid;
  ctrl_t               r_ctrl;
  logic [REG_AW-1:0]   r_rd;
  logic [REG_AW-1:0]   r_rs1;
  logic [REG_AW-1:0]   r_rs2;
  logic [XLEN-1:0]     r_pc;
  logic [STALL_CW-1:0] r_stall_cnt;

  ctrl_decode u_decode (
    .i_opcode   (bus.in_instr[6:0]),
    .o_ctrl     (w_dec_ctrl),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  assign w_rd  = REG_AW'(bus.in_instr[11:7]);
  assign w_rs1 = REG_AW'(bus.in_instr[19:15]);
  assign w_rs2 = REG_AW'(bus.in_instr[24:20]);

  // funct3/funct7 are decoded in EX, not here
  assign w_unused = ^{bus.in_instr[31:25], bus.in_instr[14:12]};

  assign w_load_en = !r_valid || bus.out_ready;

  // A load in ID/EX whose rd feeds a source the incoming opcode actually reads
  assign w_hazard = (HAZARD_EN != 0) && r_valid && r_ctrl.mem_read && (r_rd != '0) &&
                    ((w_uses_rs1 && (r_rd == w_rs1)) || (w_uses_rs2 && (r_rd == w_rs2)));

  // rst gates in_ready so nothing is accepted while the register is held in reset
  assign bus.in_ready = !rst && w_load_en && !w_hazard && !bus.flush;

  assign bus.out_valid = r_valid;
  assign bus.out_ctrl  = r_ctrl;
  assign bus.out_rd    = r_rd;
  assign bus.out_rs1   = r_rs1;
  assign bus.out_rs2   = r_rs2;
  assign bus.out_pc    = r_pc;
  assign bus.stall_cnt = r_stall_cnt;

  // ID/EX register update: flush > bubble > load > drain > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_pc        <= '0;
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_load_en && w_hazard) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
      end
    end else if (w_load_en && bus.in_valid) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_dec_ctrl;
      r_rd    <= w_rd;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_pc    <= bus.in_pc;
    end else if (w_load_en) begin
      r_valid <= 1'b0;
    end
  end

endmodule
